// File: rtl/vector_reg_file.sv
// Parametrised vector register file: DEPTH entries of LANES signed lanes,
// two masked write ports (port 2 can accumulate), one registered read port.
module vector_reg_file #(
    parameter  int unsigned LANE_W = 32,
    parameter  int unsigned LANES  = 16,
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned W      = LANES * LANE_W,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [LANES-1:0]     wr1_mask,
    input  logic [W-1:0]         wr1_data,
    input  logic                 wr2_en,
    input  logic [AW-1:0]        wr2_addr,
    input  logic [LANES-1:0]     wr2_mask,
    input  logic [W-1:0]         wr2_data,
    input  logic                 wr2_acc,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [W-1:0]         rd_data,
    output logic                 rd_valid,
    output logic [DEPTH-1:0]     dirty,
    output logic [DEPTH*W-1:0]   all_regs
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [DEPTH-1:0][W-1:0] mem_nxt;
    logic [DEPTH-1:0]        dirty_nxt;
    logic [W-1:0]            rd_sel;

    // Per-lane next value; port 2 overrides port 1 and accumulates onto the pre-edge value.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
            logic              hit1;
            logic              hit2;
            logic [LANE_W-1:0] old_lane;
            logic [LANE_W-1:0] d1;
            logic [LANE_W-1:0] d2;
            logic [LANE_W-1:0] lane_nxt;

            assign old_lane = mem[gi][gj*LANE_W +: LANE_W];
            assign d1       = wr1_data[gj*LANE_W +: LANE_W];
            assign d2       = wr2_data[gj*LANE_W +: LANE_W];
            assign hit1     = wr1_en && (wr1_addr == AW'(gi)) && wr1_mask[gj];
            assign hit2     = wr2_en && (wr2_addr == AW'(gi)) && wr2_mask[gj];

            always_comb begin
                lane_nxt = old_lane;
                if (hit1) begin
                    lane_nxt = d1;
                end
                if (hit2) begin
                    lane_nxt = wr2_acc ? LANE_W'(old_lane + d2) : d2;
                end
                if (clr) begin
                    lane_nxt = '0;
                end
            end

            assign mem_nxt[gi][gj*LANE_W +: LANE_W] = lane_nxt;
        end
    end

    // Dirty flags: sticky per entry, set only by writes that enable at least one lane.
    always_comb begin
        dirty_nxt = dirty;
        if (clr) begin
            dirty_nxt = '0;
        end else begin
            if (wr1_en && (|wr1_mask)) begin
                dirty_nxt[wr1_addr] = 1'b1;
            end
            if (wr2_en && (|wr2_mask)) begin
                dirty_nxt[wr2_addr] = 1'b1;
            end
        end
    end

    // Write-first reads see this edge's merged result; read-first reads see storage.
    if (BYPASS != 0) begin : g_wf
        assign rd_sel = mem_nxt[rd_addr];
    end else begin : g_rf
        assign rd_sel = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem      <= '0;
            dirty    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            mem      <= mem_nxt;
            dirty    <= dirty_nxt;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sel;
            end
        end
    end

    assign all_regs = mem;

endmodule

// File: tb/tb_vector_reg_file.sv
// Bench for vector_reg_file: write-first and read-first instances share stimulus
// and are checked against a lane-level reference model with a read scoreboard.
module tb_vector_reg_file;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned LANES  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned W      = LANES * LANE_W;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic               clk;
    logic               reset;
    logic               clr;
    logic               wr1_en;
    logic [AW-1:0]      wr1_addr;
    logic [LANES-1:0]   wr1_mask;
    logic [W-1:0]       wr1_data;
    logic               wr2_en;
    logic [AW-1:0]      wr2_addr;
    logic [LANES-1:0]   wr2_mask;
    logic [W-1:0]       wr2_data;
    logic               wr2_acc;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;

    logic [W-1:0]       rd_data_wf, rd_data_rf;
    logic               rd_valid_wf, rd_valid_rf;
    logic [DEPTH-1:0]   dirty_wf, dirty_rf;
    logic [DEPTH*W-1:0] all_wf, all_rf;

    vector_reg_file #(.LANE_W(LANE_W), .LANES(LANES), .DEPTH(DEPTH), .BYPASS(1)) u_wf (
        .clk(clk), .reset(reset), .clr(clr),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_mask(wr1_mask), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_mask(wr2_mask), .wr2_data(wr2_data),
        .wr2_acc(wr2_acc), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_wf), .rd_valid(rd_valid_wf), .dirty(dirty_wf), .all_regs(all_wf)
    );

    vector_reg_file #(.LANE_W(LANE_W), .LANES(LANES), .DEPTH(DEPTH), .BYPASS(0)) u_rf (
        .clk(clk), .reset(reset), .clr(clr),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_mask(wr1_mask), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_mask(wr2_mask), .wr2_data(wr2_data),
        .wr2_acc(wr2_acc), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_rf), .rd_valid(rd_valid_rf), .dirty(dirty_rf), .all_regs(all_rf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, one word per lane
    logic [LANE_W-1:0] m [DEPTH][LANES];
    logic [DEPTH-1:0]  m_dirty;
    logic [W-1:0]      q_wf[$];
    logic [W-1:0]      q_rf[$];
    logic [W-1:0]      last_wf, last_rf;
    int                n_vec, n_err;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [LANE_W-1:0] v);
        logic [W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*LANE_W +: LANE_W] = v;
        return r;
    endfunction

    task automatic idle();
        reset = 1'b0; clr = 1'b0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_mask = '0; wr1_data = '0;
        wr2_en = 1'b0; wr2_addr = '0; wr2_mask = '0; wr2_data = '0; wr2_acc = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    // Apply current inputs for one edge, update model, then compare all outputs.
    task automatic step(input string tag);
        logic [LANE_W-1:0] nx [DEPTH][LANES];
        logic [DEPTH-1:0]  nd;
        logic [W-1:0]      pre, post, e;
        logic              pend;
        nd = m_dirty;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < LANES; j++) nx[i][j] = m[i][j];
        if (reset || clr) begin
            for (int i = 0; i < DEPTH; i++)
                for (int j = 0; j < LANES; j++) nx[i][j] = '0;
            nd = '0;
        end else begin
            if (wr1_en)
                for (int j = 0; j < LANES; j++)
                    if (wr1_mask[j]) begin
                        nx[wr1_addr][j] = wr1_data[j*LANE_W +: LANE_W];
                        nd[wr1_addr] = 1'b1;
                    end
            if (wr2_en)
                for (int j = 0; j < LANES; j++)
                    if (wr2_mask[j]) begin
                        nx[wr2_addr][j] = wr2_acc ? LANE_W'(m[wr2_addr][j] + wr2_data[j*LANE_W +: LANE_W])
                                                  : wr2_data[j*LANE_W +: LANE_W];
                        nd[wr2_addr] = 1'b1;
                    end
        end
        for (int j = 0; j < LANES; j++) begin
            pre[j*LANE_W +: LANE_W]  = m[rd_addr][j];
            post[j*LANE_W +: LANE_W] = nx[rd_addr][j];
        end
        pend = rd_en && !reset;
        if (pend) begin
            q_wf.push_back(post);
            q_rf.push_back(pre);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < LANES; j++) m[i][j] = nx[i][j];
        m_dirty = nd;
        if (reset) begin
            last_wf = '0;
            last_rf = '0;
        end
        if (pend) begin
            last_wf = q_wf.pop_front();
            last_rf = q_rf.pop_front();
        end
        check({tag, ".rd_valid_wf"}, W'(rd_valid_wf), W'(pend));
        check({tag, ".rd_valid_rf"}, W'(rd_valid_rf), W'(pend));
        check({tag, ".rd_data_wf"}, rd_data_wf, last_wf);
        check({tag, ".rd_data_rf"}, rd_data_rf, last_rf);
        check({tag, ".dirty_wf"}, W'(dirty_wf), W'(m_dirty));
        check({tag, ".dirty_rf"}, W'(dirty_rf), W'(m_dirty));
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < LANES; j++) e[j*LANE_W +: LANE_W] = m[i][j];
            check($sformatf("%s.all_wf[%0d]", tag, i), all_wf[i*W +: W], e);
            check($sformatf("%s.all_rf[%0d]", tag, i), all_rf[i*W +: W], e);
        end
    endtask

    // Directed checks that do not depend on the model
    task automatic check_lane(input string tag, input int entry, input int lane, input logic [LANE_W-1:0] exp);
        check(tag, W'(all_wf[entry*W + lane*LANE_W +: LANE_W]), W'(exp));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_dirty = '0; last_wf = '0; last_rf = '0;
        idle();
        reset = 1'b1;
        step("reset0");
        step("reset1");
        idle();
        step("idle");
        check("reset.dirty", W'(dirty_wf), W'(4'b0000));

        rd_en = 1'b1; rd_addr = 2'd2;
        step("read2");
        check("read2.valid", W'(rd_valid_wf), W'(1'b1));
        check("read2.data", rd_data_wf, '0);
        idle();
        step("read2_idle");

        // Masked write, then enabled write with empty mask
        wr1_en = 1'b1; wr1_addr = 2'd1; wr1_mask = 16'h00FF; wr1_data = fill(32'h11111111);
        step("masked");
        check_lane("masked.l0", 1, 0, 32'h11111111);
        check_lane("masked.l7", 1, 7, 32'h11111111);
        check_lane("masked.l8", 1, 8, 32'h0);
        check("masked.dirty", W'(dirty_wf), W'(4'b0010));
        wr1_addr = 2'd3; wr1_mask = '0; wr1_data = fill(32'hDEADBEEF);
        step("zero_mask");
        check("zero_mask.dirty", W'(dirty_wf), W'(4'b0010));

        // Same-address collision
        idle();
        wr1_en = 1'b1; wr1_addr = 2'd0; wr1_mask = 16'hFFFF; wr1_data = fill(32'd5);
        wr2_en = 1'b1; wr2_addr = 2'd0; wr2_mask = 16'h000F; wr2_data = fill(32'd9);
        step("collide");
        check_lane("collide.l3", 0, 3, 32'd9);
        check_lane("collide.l4", 0, 4, 32'd5);

        // Accumulate wrap with same-cycle port 1 write to another lane
        idle();
        wr1_en = 1'b1; wr1_addr = 2'd2; wr1_mask = 16'h0001; wr1_data = fill(32'h7FFFFFFF);
        step("acc_seed");
        wr1_mask = 16'h0002; wr1_data = fill(32'd7);
        wr2_en = 1'b1; wr2_addr = 2'd2; wr2_mask = 16'h0001; wr2_data = fill(32'd1); wr2_acc = 1'b1;
        step("acc_wrap");
        check_lane("acc_wrap.l0", 2, 0, 32'h80000000);
        check_lane("acc_wrap.l1", 2, 1, 32'd7);

        // Both ports on one lane with accumulate: old value, never port 1's
        wr1_mask = 16'h0001; wr1_data = fill(32'd100);
        wr2_data = fill(32'hFFFFFFFF);
        step("acc_collide");
        check_lane("acc_collide.l0", 2, 0, 32'h7FFFFFFF);

        // Read-during-write and read-during-clear
        idle();
        wr1_en = 1'b1; wr1_addr = 2'd3; wr1_mask = 16'h0001; wr1_data = fill(32'h5);
        step("rdw_seed");
        wr1_data = fill(32'hA); rd_en = 1'b1; rd_addr = 2'd3;
        step("rdw");
        check("rdw.wf", W'(rd_data_wf[LANE_W-1:0]), W'(32'hA));
        check("rdw.rf", W'(rd_data_rf[LANE_W-1:0]), W'(32'h5));
        idle();
        clr = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
        step("rdclr");
        check("rdclr.wf", rd_data_wf, '0);
        check("rdclr.rf", W'(rd_data_rf[LANE_W-1:0]), W'(32'd9));
        idle();
        step("hold");

        // Reset mid-stream with continuous reads and writes
        for (int k = 0; k < 6; k++) begin
            idle();
            rd_en = 1'b1; rd_addr = AW'(k);
            wr1_en = 1'b1; wr1_addr = AW'(k + 1); wr1_mask = 16'hFFFF; wr1_data = fill(32'(k + 20));
            reset = (k == 3);
            step($sformatf("midrst%0d", k));
        end

        // Randomised traffic including boundary data and occasional clr/reset
        for (int k = 0; k < 300; k++) begin
            idle();
            reset    = ($urandom_range(0, 59) == 0);
            clr      = ($urandom_range(0, 29) == 0);
            wr1_en   = $urandom_range(0, 1) == 1;
            wr1_addr = AW'($urandom_range(0, DEPTH - 1));
            wr1_mask = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom());
            wr2_en   = $urandom_range(0, 1) == 1;
            wr2_addr = AW'($urandom_range(0, DEPTH - 1));
            wr2_mask = ($urandom_range(0, 7) == 0) ? 16'hFFFF : LANES'($urandom());
            wr2_acc  = $urandom_range(0, 1) == 1;
            for (int j = 0; j < LANES; j++) begin
                wr1_data[j*LANE_W +: LANE_W] = $urandom();
                case ($urandom_range(0, 3))
                    0:       wr2_data[j*LANE_W +: LANE_W] = 32'h7FFFFFFF;
                    1:       wr2_data[j*LANE_W +: LANE_W] = 32'hFFFFFFFF;
                    default: wr2_data[j*LANE_W +: LANE_W] = $urandom();
                endcase
            end
            rd_en   = $urandom_range(0, 3) != 0;
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            step($sformatf("rand%0d", k));
        end

        idle();
        step("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
